// File: rtl/acc_bank_serial_if.sv
// acc_bank_serial_if
//   Bundles the control and ALU-facing signals of the serial accumulator bank.
//   Master side (control FSM / ALU) drives:
//     start, load_en, reg_sel, parallel_in, alu_digit, alu_carry
//   Slave side (acc_bank_serial) drives:
//     rd_digit, acc_bits, busy, done, carry_flag, zero_flag
//   The parameters must match the ones given to the acc_bank_serial instance.
interface acc_bank_serial_if #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1,
  parameter int NREGS = 2
);
  localparam int SELW = $clog2(NREGS);

  logic             start;
  logic             load_en;
  logic [SELW-1:0]  reg_sel;
  logic [WIDTH-1:0] parallel_in;
  logic [DIGIT-1:0] alu_digit;
  logic             alu_carry;
  logic [DIGIT-1:0] rd_digit;
  logic [WIDTH-1:0] acc_bits;
  logic             busy;
  logic             done;
  logic             carry_flag;
  logic             zero_flag;

  modport master (
    output start, load_en, reg_sel, parallel_in, alu_digit, alu_carry,
    input  rd_digit, acc_bits, busy, done, carry_flag, zero_flag
  );

  modport slave (
    input  start, load_en, reg_sel, parallel_in, alu_digit, alu_carry,
    output rd_digit, acc_bits, busy, done, carry_flag, zero_flag
  );
endinterface

// File: rtl/acc_bank_serial.sv
// acc_bank_serial
//   Bank of NREGS accumulator registers, WIDTH bits each. A register can be
//   parallel-loaded, or rewritten digit-serially (DIGIT bits per cycle, LSB
//   digit first) from an external ALU. The current operand digit is offered
//   combinationally on rd_digit and the ALU result digit is written back at
//   the same clock edge. Carry and zero flags are latched at the end of a pass.
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; clears bank, flags and FSM
//   bus   : acc_bank_serial_if.slave
//           start/load_en/reg_sel/parallel_in : control inputs
//           alu_digit/alu_carry               : ALU result for current digit
//           rd_digit/acc_bits                 : active register view
//           busy/done/carry_flag/zero_flag    : handshake and status
module acc_bank_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1,
  parameter int NREGS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  acc_bank_serial_if.slave   bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SELW = $clog2(NREGS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state;
  state_t state_next;

  // Registers are stored as arrays of digits so a digit can be addressed
  // directly by digit_idx without computing bit offsets.
  logic [NDIG-1:0][DIGIT-1:0] regs [NREGS];

  logic [SELW-1:0]            act_sel;
  logic [IDXW-1:0]            digit_idx;
  logic                       zacc;
  logic                       done_q;
  logic                       carry_q;
  logic                       zero_q;

  logic                       begin_pass;
  logic                       last_digit;
  logic                       digit_zero;
  logic [SELW-1:0]            act;
  logic [NDIG-1:0][DIGIT-1:0] active_word;

  // While a pass runs the latched selector owns the bank view, so reg_sel
  // may wander freely without disturbing the ALU operand.
  assign act         = (state == SHIFT) ? act_sel : bus.reg_sel;
  assign active_word = regs[act];
  assign digit_zero  = (bus.alu_digit == '0);

  assign bus.acc_bits   = active_word;
  assign bus.rd_digit   = active_word[digit_idx];
  assign bus.busy       = (state == SHIFT);
  assign bus.done       = done_q;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;

  // Next-state logic. A simultaneous load request suppresses start, so the
  // load always takes priority in IDLE.
  always_comb begin
    state_next = state;
    begin_pass = 1'b0;
    last_digit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.load_en) begin
          begin_pass = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (digit_idx == LAST_IDX) begin
          last_digit = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, bank storage and pass bookkeeping. Reset wipes the whole
  // bank so an interrupted pass never leaves a half-written register behind.
  // done is a single-cycle pulse: it is cleared on every edge unless the
  // final digit is being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      act_sel   <= '0;
      digit_idx <= '0;
      zacc      <= 1'b0;
      done_q    <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.load_en) begin
          regs[bus.reg_sel] <= bus.parallel_in;
        end
        if (begin_pass) begin
          act_sel   <= bus.reg_sel;
          digit_idx <= '0;
          zacc      <= 1'b1;
        end
      end else begin
        regs[act_sel][digit_idx] <= bus.alu_digit;
        zacc <= zacc & digit_zero;
        if (last_digit) begin
          carry_q   <= bus.alu_carry;
          zero_q    <= zacc & digit_zero;
          done_q    <= 1'b1;
          digit_idx <= '0;
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/acc_bank_serial.md
# acc_bank_serial

Parametrised successor to the single bit-serial accumulator. It holds a bank of `NREGS` accumulator registers, each `WIDTH` bits. Every register supports parallel load and digit-serial write-back of ALU results, `DIGIT` bits per cycle, LSB digit first. The block presents the current operand digit to the ALU and captures the result digit in the same cycle. It also provides a start/busy/done handshake to the control FSM and latches carry and zero flags at the end of each pass.

## Interface
- `WIDTH`, default 8: register width in bits. Must be a multiple of `DIGIT`.
- `DIGIT`, default 1: bits processed per cycle. Legal values are 1, 2, 4 or 8, and must divide `WIDTH`.
- `NREGS`, default 2: number of registers in the bank. Must be ≥ 2.
- `NDIG`, derived, = `WIDTH/DIGIT`: digits per pass.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a serial pass on register `reg_sel`.
- `load_en` in 1: parallel-load `parallel_in` into register `reg_sel`.
- `reg_sel` in `$clog2(NREGS)`: register select.
- `parallel_in` in `WIDTH`: parallel load data.
- `alu_digit` in `DIGIT`: result digit from the ALU.
- `alu_carry` in 1: ALU carry-out for the current digit.
- `rd_digit` out `DIGIT`: current operand digit of the active register (combinational).
- `acc_bits` out `WIDTH`: contents of the active register (combinational).
- `busy` out 1: a serial pass is in progress.
- `done` out 1: one-cycle pulse when a pass completes.
- `carry_flag` out 1: `alu_carry` captured on the last digit.
- `zero_flag` out 1: 1 if every result digit of the last pass was 0.

## Operation
- FSM has two states, IDLE and SHIFT.
- In IDLE:
  - `load_en=1`: at the clock edge, `regs[reg_sel] <= parallel_in`. Flags are unchanged.
  - `start=1` with `load_en=0`: latch `reg_sel` into `act_sel`, set `digit_idx <= 0` and `zacc <= 1`, go to SHIFT.
  - `start` and `load_en` both high: load wins and `start` is ignored.
- In SHIFT, at each edge:
  - `regs[act_sel][digit_idx*DIGIT +: DIGIT] <= alu_digit`.
  - `zacc <= zacc & (alu_digit == 0)`.
  - `digit_idx++`.
- Last digit (`digit_idx == NDIG-1`), at the same edge:
  - `carry_flag <= alu_carry`.
  - `zero_flag <= zacc & (alu_digit == 0)`.
  - `done <= 1`.
  - State returns to IDLE.
- Active register: `act_sel` while in SHIFT, `reg_sel` while in IDLE.
- `rd_digit` = active register bits `[digit_idx*DIGIT +: DIGIT]`. It shows the value before that edge's write (read-before-write), so the ALU reads its operand and returns the result in the same cycle. In IDLE, `digit_idx = 0`.
- `acc_bits` = full active register.
- Inputs ignored during SHIFT: `load_en`, `start`, and changes on `reg_sel`.
- `busy` = (state == SHIFT).
- Registers not selected are never modified.

## Timing
- Reset (asynchronous, immediate, including mid-pass):
  - All registers are cleared to 0.
  - State goes to IDLE; `digit_idx` and `act_sel` go to 0.
  - `busy`, `done`, `carry_flag` and `zero_flag` all go to 0.
  - A partially written register is cleared, not left partially written.
- Load latency: data is visible on `acc_bits` in the cycle after the `load_en` edge.
- Pass latency, with `start` sampled at edge E0:
  - `busy` is high from E0 through E`NDIG` (`NDIG` cycles).
  - Digits are written at E1..E`NDIG`.
  - `done` is high for exactly the one cycle after E`NDIG`, the same cycle `busy` is low again.
  - Flags are valid from E`NDIG` onward and hold until the next pass ends or reset.
- Back-to-back passes: `start` sampled in the cycle where `done` is high is accepted, giving zero idle cycles.
- `DIGIT == WIDTH` (`NDIG=1`): a pass takes one cycle; `done` follows immediately.
- `digit_idx` width is `max(1, $clog2(NDIG))`. It never wraps inside a pass, and returns to 0 on entering IDLE.

## Test plan
- Reset and load. `WIDTH=8, DIGIT=2, NREGS=4`: assert `rst_n=0` mid-cycle, then load `0xA5` into reg 2.
  - Required: all outputs 0 immediately on reset.
  - Required: `acc_bits=0xA5` one cycle after load with `reg_sel=2`; regs 0, 1, 3 read 0.
- Serial pass. Reg 1 = `0x3C`; `start`; bench returns `alu_digit = ~rd_digit` each cycle.
  - Required: `rd_digit` sequence 0,3,3,0.
  - Required: `busy` high 4 cycles, `done` a 1-cycle pulse, reg 1 = `0xC3`, `zero_flag=0`.
- Flags. Pass where every `alu_digit=0`, with `alu_carry=1` only on the last digit.
  - Required: register = `0x00`, `zero_flag=1`, `carry_flag=1`.
  - Then a second pass with a nonzero digit in digit 1 and `carry=0`. Required: `zero_flag=0`, `carry_flag=0`.
- Conflicts.
  - `start` and `load_en` together: required is load only, with `busy` staying 0.
  - During SHIFT, toggle `reg_sel`, `load_en` and `start`: required is that only the latched register changes and the pass still takes 4 cycles.
- Back-to-back passes. Assert `start` in the `done` cycle.
  - Required: second pass `busy` begins with no gap; total 8 busy cycles over two `done` pulses.
- Reset mid-pass and `DIGIT=WIDTH`. Reset after 2 digits.
  - Required: `busy=0`, register 0, no `done`.
  - Separately, with `WIDTH=8, DIGIT=8`: a pass completes in 1 cycle with a correct write.
